// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-request record used by the writeback arbiter and its result buffer.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Mul/div result buffer: in-order FIFO with per-entry valid bits, invalidate-by-address and a busy scoreboard.
// Push must only be asserted when not full and pop only when not empty; both visible on head/busy next cycle.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  inv,
  input  logic [REG_ADDR_W-1:0] inv_addr,
  output wr_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [31:0]           busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    head.valid = vld_q[rd_ptr];
    head.addr  = addr_q[rd_ptr];
    head.data  = data_q[rd_ptr];
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy[addr_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  // Payload needs no reset: an entry is only observed through its valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // A younger ALU write to the same register kills every older buffered result.
      for (int i = 0; i < DEPTH; i++) begin
        if (inv && vld_q[i] && addr_q[i] == inv_addr) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU writes win, mul/div results buffered in wb_fifo; 1-cycle registered output.
// md_ready = buffer not full; optional WB_FWD_EN adds fwd_* bypass of the write being selected this cycle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_wr,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  wr,
  output logic [REG_ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0]     data3,
  output logic [31:0]           busy
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  wr_req_t head;
  wr_req_t sel;
  logic    full;
  logic    empty;
  logic    alu_sel;
  logic    push;
  logic    pop;

  assign alu_sel  = alu_wr && (alu_addr != '0);
  assign md_ready = !full;
  // Zero-destination results are accepted and dropped rather than buffered.
  assign push     = md_valid && md_ready && (md_addr != '0);
  assign pop      = !alu_sel && !empty;

  always_comb begin
    sel.valid = alu_sel || (pop && head.valid);
    sel.addr  = alu_sel ? alu_addr : head.addr;
    sel.data  = alu_sel ? alu_data : head.data;
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (md_addr),
    .push_data (md_data),
    .pop       (pop),
    .inv       (alu_sel),
    .inv_addr  (alu_addr),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .busy      (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr    <= 1'b0;
      addr3 <= '0;
      data3 <= '0;
    end else begin
      wr <= sel.valid;
      if (sel.valid) begin
        addr3 <= sel.addr;
        data3 <= sel.data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = sel.valid;
  assign fwd_addr  = sel.addr;
  assign fwd_data  = sel.data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model, directed scenarios plus randomized traffic.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        wr;
  logic [4:0]  addr3;
  logic [31:0] data3;
  logic [31:0] busy;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_wr   (alu_wr),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .wr       (wr),
    .addr3    (addr3),
    .data3    (data3),
    .busy     (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t mq[$];     // model of buffered mul/div results, oldest first
  ent_t exp_q[$];  // expected registered output, one entry per clock

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (mq[i]) if (mq[i].v) b[mq[i].a] = 1'b1;
    return b;
  endfunction

  // Monitor: after every edge, compare the registered write port with the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr", {31'd0, wr}, {31'd0, e.v});
        if (e.v) begin
          check("addr3", {27'd0, addr3}, {27'd0, e.a});
          check("data3", data3, e.d);
        end
      end else begin
        check("idle_wr", {31'd0, wr}, 32'd0);
      end
    end
  end

  // Called 2 time units after a rising edge; returns at the same phase one cycle later.
  task automatic step(input bit aw, input bit [4:0] aa, input bit [31:0] ad,
                      input bit mv, input bit [4:0] ma, input bit [31:0] md);
    ent_t o;
    ent_t e;
    bit   rdy;
    rdy = (mq.size() < DEPTH);
    check("md_ready", {31'd0, md_ready}, {31'd0, rdy});
    check("busy", busy, model_busy());
    alu_wr = aw; alu_addr = aa; alu_data = ad;
    md_valid = mv; md_addr = ma; md_data = md;
    o = '{v: 1'b0, a: 5'd0, d: 32'd0};
    if (aw && aa != 0) begin
      o = '{v: 1'b1, a: aa, d: ad};
      foreach (mq[i]) if (mq[i].a == aa) mq[i].v = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.v) o = e;
    end
    if (mv && rdy && ma != 0) mq.push_back('{v: 1'b1, a: ma, d: md});
    exp_q.push_back(o);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int cycles);
    alu_wr = 1'b0; md_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_addr3", {27'd0, addr3}, 32'd0);
    check("rst_data3", data3, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd1);
    check("rst_busy", busy, 32'd0);
    mq.delete();
    exp_q.delete();
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    alu_wr = 1'b0; alu_addr = '0; alu_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    #3;
    check("init_wr", {31'd0, wr}, 32'd0);
    check("init_md_ready", {31'd0, md_ready}, 32'd1);
    check("init_busy", busy, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // single ALU write
    step(1, 5, 32'h1234, 0, 0, 0);
    idle(2);

    // md result parked behind a 3-cycle ALU burst
    step(1, 3, 32'h0301, 1, 8, 32'hAA);
    step(1, 3, 32'h0302, 0, 0, 0);
    step(1, 3, 32'h0303, 0, 0, 0);
    idle(3);

    // back-to-back md results against a busy ALU: third waits for space
    step(1, 1, 32'h11, 1, 10, 32'hA0);
    step(1, 1, 32'h12, 1, 11, 32'hA1);
    step(1, 1, 32'h13, 1, 12, 32'hA2);
    step(1, 1, 32'h14, 1, 12, 32'hA2);
    step(0, 0, 0, 1, 12, 32'hA2);
    step(0, 0, 0, 1, 12, 32'hA2);
    idle(4);

    // ALU overwrites a buffered result to the same register
    step(1, 2, 32'h22, 1, 9, 32'h55);
    step(1, 9, 32'h77, 0, 0, 0);
    idle(4);

    // zero destinations are never written or buffered
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    step(0, 0, 0, 1, 0, 32'hBEEF);
    idle(2);

    // reset with two results buffered
    step(1, 1, 32'h31, 1, 13, 32'hC0);
    step(1, 1, 32'h32, 1, 14, 32'hC1);
    do_reset(1);
    idle(4);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      end
    end
    idle(DEPTH + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the depth of the mul/div result buffer (power of two, 2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 alu_wr  input  1  SHALL mark a single-cycle ALU result this cycle (cannot be stalled).
REQ-005 alu_addr  input  5  SHALL give the ALU destination register.
REQ-006 alu_data  input  32  SHALL give the ALU result.
REQ-007 md_valid  input  1  SHALL mark a mul/div result offered this cycle.
REQ-008 md_ready  output  1  SHALL accept md result; transfer occurs when md_valid && md_ready.
REQ-009 md_addr  input  5  SHALL give the mul/div destination register.
REQ-010 md_data  input  32  SHALL give the mul/div result.
REQ-011 wr  output  1  SHALL be the register-file write enable.
REQ-012 addr3  output  5  SHALL be the register-file write address.
REQ-013 data3  output  32  SHALL be the register-file write data.
REQ-014 busy  output  32  SHALL flag, per register, a buffered mul/div write not yet issued; bit 0 always 0.

Function
REQ-015 wr/addr3/data3 SHALL be registered: a write selected in cycle N appears on the outputs in cycle N+1, held exactly one cycle.
REQ-016 Writes with destination 0 SHALL be discarded at input (never buffered, never issued, wr stays 0).
REQ-017 ALU write SHALL have absolute priority; when alu_wr && alu_addr!=0, the ALU write is issued that cycle.
REQ-018 Otherwise the FIFO head, if non-empty, SHALL be issued and popped that cycle.
REQ-019 md results SHALL be pushed into a FIFO_DEPTH-entry FIFO; md_ready = FIFO not full (combinational from count).
REQ-020 Full FIFO with a pop in the same cycle SHALL still deassert md_ready (no same-cycle push-through when full).
REQ-021 Empty FIFO with md_valid and no ALU write SHALL still route via the FIFO (minimum md latency 2 cycles to wr).
REQ-022 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 An issued ALU write whose addr equals a buffered entry's addr SHALL invalidate that entry (ALU result is younger); invalidated entries pop without issuing.
REQ-024 busy[r] SHALL be 1 iff at least one valid buffered entry targets r; updated combinationally from FIFO state.
REQ-025 Write ordering to the same register from the FIFO SHALL be preserved (FIFO order).

Reset
REQ-026 On reset low: wr=0, addr3=0, data3=0, FIFO count=0, pointers=0, all entries invalid, md_ready=1, busy=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results immediately; no write is issued after reset release until new input.

Configuration
REQ-028 Macro WB_FWD_EN defined: outputs fwd_valid(1), fwd_addr(5), fwd_data(32) SHALL present the write being selected this cycle (combinational, one cycle before wr) for bypass.
REQ-029 Macro WB_FWD_EN undefined: fwd ports SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold REG_ADDR_W=5, DATA_W=32, and the write-request record type (valid, addr, data).
REQ-031 FIFO SHALL be a sub-module wb_fifo (storage, pointers, count, per-entry valid, invalidate-by-addr port).

Verification
REQ-032 alu_wr=1, alu_addr=5, alu_data=0x1234 at cycle 0 -> wr=1, addr3=5, data3=0x1234 at cycle 1 only.
REQ-033 md_valid with addr=8,data=0xAA while alu_wr held 1 (addr=3) for 3 cycles -> busy[8]=1 throughout; md write issued on cycle after alu_wr drops.
REQ-034 Three md results back-to-back, ALU continuously busy, FIFO_DEPTH=2 -> md_ready=0 after second accept; third held until pop.
REQ-035 md result addr=9 buffered, then alu_wr addr=9 data=0x77 -> only 0x77 written to 9; busy[9] clears; no later write to 9.
REQ-036 alu_addr=0 and md_addr=0 with valid -> wr never asserts, busy stays 0, md_ready stays 1.
REQ-037 Two md entries buffered, reset pulsed low one cycle -> wr=0, busy=0, md_ready=1; no stale write after release.
